// File: rtl/ifetch_prefetch_unit_pkg.sv
// Shared defaults and helpers for the instruction-fetch/prefetch slice.
package ifetch_prefetch_unit_pkg;
  localparam int          DEF_ADDR_W      = 32;
  localparam int          DEF_INSTR_W     = 32;
  localparam int          DEF_QUEUE_DEPTH = 4;
  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/ifetch_prefetch_unit_if.sv
// Fetch-stage bus: redirect input, instruction-memory port and decode handshake.
interface ifetch_prefetch_unit_if
  import ifetch_prefetch_unit_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int INSTR_W     = DEF_INSTR_W,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
);
  localparam int CNT_W = cnt_width(QUEUE_DEPTH);

  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [ADDR_W-1:0]  out_pc_plus4;
  logic [CNT_W-1:0]   queue_count;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, queue_count
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, queue_count
  );
endinterface

// File: rtl/ifetch_prefetch_unit_queue.sv
// Prefetch FIFO with a registered head; flush (and reset) beat push and pop.
module ifetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_head;
  logic             w_pop;
  logic [PTR_W-1:0] w_rd_next;

  assign w_pop     = i_pop && (r_count != '0);
  assign w_rd_next = r_rd_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (i_push && !i_flush && !srst) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Head reloads from the incoming word when the queue is (or becomes) a single entry.
  always_ff @(posedge clk) begin
    if (srst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (i_push && ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop))) begin
        r_head <= i_din;
      end else if (w_pop) begin
        r_head <= r_mem[w_rd_next];
      end
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;
endmodule

// File: rtl/ifetch_prefetch_unit.sv
// Instruction-fetch stage: PC register, single in-flight read, credit-limited issue
// into a prefetch queue feeding decode.
module ifetch_prefetch_unit
  import ifetch_prefetch_unit_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                INSTR_W     = DEF_INSTR_W,
  parameter int                QUEUE_DEPTH = DEF_QUEUE_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC)
) (
  input  logic clk,
  input  logic rst,
  ifetch_prefetch_unit_if.master bus
);
  localparam int CNT_W   = cnt_width(QUEUE_DEPTH);
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_inflight_pc;
  logic               r_inflight;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W:0]     w_pending;
  logic [ENTRY_W-1:0] w_head;

  // A pop this cycle is deliberately not credited, keeping out_ready off the req path.
  assign w_pending = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_issue   = !rst && !bus.redirect_valid && (w_pending < (CNT_W+1)'(QUEUE_DEPTH));
  assign w_push    = r_inflight && !bus.redirect_valid && !rst;
  assign w_pop     = (w_count != '0) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(4);
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  ifetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .srst    (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_din   ({r_inflight_pc, bus.imem_rdata}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Decode sees a NOP rather than a stale head while the queue is empty.
  assign bus.imem_req     = w_issue;
  assign bus.imem_addr    = r_fetch_pc;
  assign bus.out_valid    = (w_count != '0);
  assign bus.out_pc       = w_head[ENTRY_W-1:INSTR_W];
  assign bus.out_instr    = bus.out_valid ? w_head[INSTR_W-1:0] : INSTR_W'(NOP_INSTR);
  assign bus.out_pc_plus4 = w_head[ENTRY_W-1:INSTR_W] + ADDR_W'(4);
  assign bus.queue_count  = w_count;
endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// Self-checking bench: directed scenarios plus randomized ready/redirect/reset traffic
// checked against an in-order delivered-PC reference model.
module tb_ifetch_prefetch_unit;
  localparam int          AW    = 32;
  localparam int          IW    = 32;
  localparam int          QD    = 4;
  localparam logic [31:0] RPC_A = 32'h0000_0000;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  ifetch_prefetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW), .QUEUE_DEPTH(QD)) bus_a ();
  ifetch_prefetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW), .QUEUE_DEPTH(QD)) bus_b ();

  ifetch_prefetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .QUEUE_DEPTH(QD), .RESET_PC(RPC_A)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  ifetch_prefetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .QUEUE_DEPTH(QD), .RESET_PC(RPC_B)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // 1-cycle memory; garbage when no request so stray pushes are visible.
  always @(posedge clk) begin
    bus_a.imem_rdata <= bus_a.imem_req ? mem_word(bus_a.imem_addr) : $urandom;
    bus_b.imem_rdata <= bus_b.imem_req ? mem_word(bus_b.imem_addr) : $urandom;
  end

  int          checks   = 0;
  int          failures = 0;
  int          pops     = 0;
  bit          inv_en   = 1'b0;
  logic [31:0] exp_pc   = RPC_A;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Called at negedge after inputs are set: settle, check invariants and any delivery.
  task automatic sample();
    #1;
    if (inv_en) begin
      chk("inv_valid_vs_count", {63'd0, bus_a.out_valid}, {63'd0, (bus_a.queue_count != 0)});
      chk("inv_count_le_depth", {63'd0, (bus_a.queue_count <= QD)}, 64'd1);
      if (!rst_a && !bus_a.redirect_valid && bus_a.out_valid === 1'b1 && bus_a.out_ready) begin
        $display("deliver pc=0x%08h instr=0x%08h", bus_a.out_pc, bus_a.out_instr);
        chk("deliver_pc", {32'd0, bus_a.out_pc}, {32'd0, exp_pc});
        chk("deliver_instr", {32'd0, bus_a.out_instr}, {32'd0, mem_word(exp_pc)});
        chk("deliver_pc_plus4", {32'd0, bus_a.out_pc_plus4}, {32'd0, exp_pc + 32'd4});
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
  endtask

  task automatic advance();
    if (rst_a) exp_pc = RPC_A;
    else if (bus_a.redirect_valid) exp_pc = {bus_a.redirect_pc[31:2], 2'b00};
    @(posedge clk);
    @(negedge clk);
    inv_en = 1'b1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      sample();
      advance();
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.redirect_valid = 1'b0;
    bus_a.redirect_pc    = '0;
    bus_a.out_ready      = 1'b1;
    bus_b.redirect_valid = 1'b0;
    bus_b.redirect_pc    = '0;
    bus_b.out_ready      = 1'b1;
    @(negedge clk);

    // Reset held two cycles
    sample(); advance();
    sample();
    chk("rst_req", {63'd0, bus_a.imem_req}, 64'd0);
    chk("rst_valid", {63'd0, bus_a.out_valid}, 64'd0);
    chk("rst_count", {61'd0, bus_a.queue_count}, 64'd0);
    chk("rst_addr", {32'd0, bus_a.imem_addr}, {32'd0, RPC_A});
    advance();

    // Sequential stream, two-cycle request-to-visible latency, then 1/cycle
    rst_a = 1'b0;
    sample();
    chk("t1_req_c0", {63'd0, bus_a.imem_req}, 64'd1);
    chk("t1_valid_c0", {63'd0, bus_a.out_valid}, 64'd0);
    advance();
    sample();
    chk("t1_valid_c1", {63'd0, bus_a.out_valid}, 64'd0);
    advance();
    sample();
    chk("t1_valid_c2", {63'd0, bus_a.out_valid}, 64'd1);
    chk("t1_first_pc", {32'd0, bus_a.out_pc}, 64'd0);
    advance();
    for (int k = 0; k < 6; k++) begin
      sample();
      chk("t1_throughput", {63'd0, bus_a.out_valid}, 64'd1);
      advance();
    end

    // Backpressure: saturate, then resume with no gap
    bus_a.out_ready = 1'b0;
    run(10);
    sample();
    chk("t2_count_full", {61'd0, bus_a.queue_count}, 64'd4);
    chk("t2_req_off", {63'd0, bus_a.imem_req}, 64'd0);
    advance();
    bus_a.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sample();
      chk("t2_no_gap", {63'd0, bus_a.out_valid}, 64'd1);
      advance();
    end

    // Redirect with full queue and simultaneous ready
    bus_a.out_ready = 1'b0;
    run(6);
    sample();
    chk("t3_full_before", {61'd0, bus_a.queue_count}, 64'd4);
    advance();
    bus_a.out_ready = 1'b1;
    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_pc = 32'h40;
    sample();
    chk("t3_req_during_redirect", {63'd0, bus_a.imem_req}, 64'd0);
    advance();
    bus_a.redirect_valid = 1'b0;
    sample();
    chk("t3_count_flushed", {61'd0, bus_a.queue_count}, 64'd0);
    chk("t3_valid_flushed", {63'd0, bus_a.out_valid}, 64'd0);
    chk("t3_req_target", {63'd0, bus_a.imem_req}, 64'd1);
    chk("t3_addr_target", {32'd0, bus_a.imem_addr}, 64'h40);
    advance();
    sample();
    chk("t3_valid_r2", {63'd0, bus_a.out_valid}, 64'd0);
    advance();
    sample();
    chk("t3_valid_r3", {63'd0, bus_a.out_valid}, 64'd1);
    chk("t3_pc_r3", {32'd0, bus_a.out_pc}, 64'h40);
    chk("t3_instr_r3", {32'd0, bus_a.out_instr}, 64'h1000_0010);
    advance();
    run(4);

    // Misaligned target, then back-to-back redirects
    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_pc = 32'h43;
    sample(); advance();
    bus_a.redirect_valid = 1'b0;
    sample();
    chk("t4_align", {32'd0, bus_a.imem_addr}, 64'h40);
    advance();
    run(3);
    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_pc = 32'h80;
    sample(); advance();
    bus_a.redirect_pc = 32'hC0;
    sample(); advance();
    bus_a.redirect_valid = 1'b0;
    sample(); advance();
    sample(); advance();
    sample();
    chk("t4_last_target", {32'd0, bus_a.out_pc}, 64'hC0);
    advance();
    run(4);

    // Reset mid-stream with queue at 3 and a read in flight
    bus_a.out_ready = 1'b0;
    for (int k = 0; k < 20 && bus_a.queue_count != 3; k++) begin
      sample(); advance();
    end
    sample();
    chk("t6_reach3", {61'd0, bus_a.queue_count}, 64'd3);
    advance();
    rst_a = 1'b1;
    sample(); advance();
    rst_a = 1'b0;
    bus_a.out_ready = 1'b1;
    sample();
    chk("t6_valid", {63'd0, bus_a.out_valid}, 64'd0);
    chk("t6_count", {61'd0, bus_a.queue_count}, 64'd0);
    chk("t6_addr", {32'd0, bus_a.imem_addr}, {32'd0, RPC_A});
    advance();
    run(6);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      bus_a.out_ready      = ($urandom_range(0, 9) < 7);
      bus_a.redirect_valid = ($urandom_range(0, 19) == 0);
      bus_a.redirect_pc    = $urandom & 32'h0000_0FFF;
      rst_a                = ($urandom_range(0, 99) == 0);
      sample(); advance();
    end
    rst_a = 1'b0;
    bus_a.redirect_valid = 1'b0;
    bus_a.out_ready = 1'b1;
    run(3);
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("drain_valid", {63'd0, bus_a.out_valid}, 64'd1);
      advance();
    end

    // Wrap-around reset PC on the second instance
    rst_b = 1'b0;
    #1;
    chk("t5_addr0", {32'd0, bus_b.imem_addr}, 64'hFFFF_FFF8);
    chk("t5_valid0", {63'd0, bus_b.out_valid}, 64'd0);
    @(negedge clk); #1;
    chk("t5_valid1", {63'd0, bus_b.out_valid}, 64'd0);
    @(negedge clk); #1;
    $display("deliver_b pc=0x%08h instr=0x%08h", bus_b.out_pc, bus_b.out_instr);
    chk("t5_pc_f8", {32'd0, bus_b.out_pc}, 64'hFFFF_FFF8);
    chk("t5_instr_f8", {32'd0, bus_b.out_instr}, 64'h4FFF_FFFE);
    @(negedge clk); #1;
    $display("deliver_b pc=0x%08h instr=0x%08h", bus_b.out_pc, bus_b.out_instr);
    chk("t5_pc_fc", {32'd0, bus_b.out_pc}, 64'hFFFF_FFFC);
    chk("t5_plus4_fc", {32'd0, bus_b.out_pc_plus4}, 64'd0);
    @(negedge clk); #1;
    $display("deliver_b pc=0x%08h instr=0x%08h", bus_b.out_pc, bus_b.out_instr);
    chk("t5_pc_wrap", {32'd0, bus_b.out_pc}, 64'd0);
    chk("t5_instr_wrap", {32'd0, bus_b.out_instr}, 64'h1000_0000);

    chk("total_deliveries_seen", {63'd0, (pops > 40)}, 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
